// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 LSB-first serial receiver producing single-byte strobes for rx_bridge
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic       rxen,
  output logic [7:0] rxdb,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int          HALF_BIT = CLKS_PER_BIT / 2;
  localparam logic [15:0] HALF_M1  = 16'(HALF_BIT - 1);
  localparam logic [15:0] BIT_M1   = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        rxd_m;
  logic        rxd_s;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= 16'd0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      rxdb      <= 8'h00;
      rxen      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rxen      <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= 16'd0;
          if (!rxd_s) state <= S_START;
        end
        S_START: begin
          if (cnt == HALF_M1) begin
            cnt     <= 16'd0;
            bit_idx <= 3'd0;
            state   <= rxd_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (cnt == BIT_M1) begin
            shreg[bit_idx] <= rxd_s;
            cnt            <= 16'd0;
            if (bit_idx == 3'd7) state <= S_STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (cnt == BIT_M1) begin
            cnt <= 16'd0;
            if (rxd_s) begin
              rxdb  <= shreg;
              rxen  <= 1'b1;
              state <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        // A held-low line must return high before a new start is accepted.
        S_BREAK: begin
          if (rxd_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb/tb_uart_rx_byte.sv - self-checking bench for uart_rx_byte with randomized bytes
module tb_uart_rx_byte;

  localparam int CPB     = 8;
  localparam int HALF    = CPB / 2;
  localparam int LAT_MIN = 2 + HALF + 9 * CPB;
  localparam int LAT_MAX = LAT_MIN + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1;
  logic       rxen;
  logic [7:0] rxdb;
  logic       frame_err;
  logic       rx_busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [7:0] ev_byte[$];
  int         ev_cyc[$];
  int         fe_cnt = 0, both_cnt = 0, dbl_cnt = 0, chg_cnt = 0;
  int         busy_run = 0, busy_max = 0, busy_total = 0;
  logic       prev_rxen = 1'b0;
  logic [7:0] prev_rxdb = 8'h00;
  logic [7:0] last_byte = 8'h00;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rxd(rxd),
    .rxen(rxen), .rxdb(rxdb), .frame_err(frame_err), .rx_busy(rx_busy)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rxen === 1'b1) begin
      ev_byte.push_back(rxdb);
      ev_cyc.push_back(cyc);
    end
    if (frame_err === 1'b1) fe_cnt++;
    if (rxen === 1'b1 && frame_err === 1'b1) both_cnt++;
    if (rxen === 1'b1 && prev_rxen === 1'b1) dbl_cnt++;
    if (rst === 1'b1 && rxen !== 1'b1 && rxdb !== prev_rxdb) chg_cnt++;
    if (rx_busy === 1'b1) begin
      busy_run++;
      busy_total++;
      if (busy_run > busy_max) busy_max = busy_run;
    end else begin
      busy_run = 0;
    end
    prev_rxen = rxen;
    prev_rxdb = rxdb;
  end

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v, output int fall);
    fall = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_v);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    rxd = 1'b1;
    #100;
    vectors++; if (rxen !== 1'b0) begin miscompares++; $display("FAIL reset_rxen: got %b expected 0", rxen); end
    vectors++; if (rxdb !== 8'h00) begin miscompares++; $display("FAIL reset_rxdb: got %h expected 00", rxdb); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    vectors++; if (rx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_rx_busy: got %b expected 0", rx_busy); end
    @(negedge clk);
    rst = 1'b1;
    ev_byte.delete(); ev_cyc.delete();
    fe_cnt = 0; busy_total = 0;
    idle(500);
    vectors++; if (ev_byte.size() != 0) begin miscompares++; $display("FAIL idle_rxen_count: got %0d expected 0", ev_byte.size()); end
    vectors++; if (fe_cnt != 0) begin miscompares++; $display("FAIL idle_frame_err: got %0d expected 0", fe_cnt); end
    vectors++; if (busy_total != 0) begin miscompares++; $display("FAIL idle_busy_clocks: got %0d expected 0", busy_total); end
    vectors++; if (rxdb !== 8'h00) begin miscompares++; $display("FAIL idle_rxdb: got %h expected 00", rxdb); end
  endtask

  task automatic test_single_byte;
    int fall, fe0, lat;
    ev_byte.delete(); ev_cyc.delete();
    fe0 = fe_cnt;
    send_byte(8'hAA, 1'b1, fall);
    idle(20);
    vectors++; if (ev_byte.size() != 1) begin miscompares++; $display("FAIL single_count: got %0d expected 1", ev_byte.size()); end
    if (ev_byte.size() >= 1) begin
      lat = ev_cyc[0] - fall;
      vectors++; if (ev_byte[0] !== 8'hAA) begin miscompares++; $display("FAIL single_byte: got %h expected aa", ev_byte[0]); end
      vectors++; if (lat < LAT_MIN || lat > LAT_MAX) begin miscompares++; $display("FAIL single_latency: got %0d expected %0d..%0d", lat, LAT_MIN, LAT_MAX); end
    end
    vectors++; if (rxdb !== 8'hAA) begin miscompares++; $display("FAIL single_rxdb_held: got %h expected aa", rxdb); end
    vectors++; if (fe_cnt != fe0) begin miscompares++; $display("FAIL single_frame_err: got %0d expected 0", fe_cnt - fe0); end
    last_byte = 8'hAA;
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_q[$];
    int         fall_q[$];
    int         fall, lat;
    exp_q = '{8'hAA, 8'h04, 8'h02, 8'h01, 8'h00, 8'h07};
    for (int i = 0; i < 6; i++) exp_q.push_back(8'($urandom_range(0, 255)));
    ev_byte.delete(); ev_cyc.delete();
    foreach (exp_q[i]) begin
      send_byte(exp_q[i], 1'b1, fall);
      fall_q.push_back(fall);
    end
    idle(20);
    vectors++; if (ev_byte.size() != exp_q.size()) begin miscompares++; $display("FAIL b2b_count: got %0d expected %0d", ev_byte.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      if (i < ev_byte.size()) begin
        lat = ev_cyc[i] - fall_q[i];
        vectors++; if (ev_byte[i] !== exp_q[i]) begin miscompares++; $display("FAIL b2b_byte[%0d]: got %h expected %h", i, ev_byte[i], exp_q[i]); end
        vectors++; if (lat < LAT_MIN || lat > LAT_MAX) begin miscompares++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d..%0d", i, lat, LAT_MIN, LAT_MAX); end
      end
    end
    last_byte = exp_q[exp_q.size() - 1];
    vectors++; if (rxdb !== last_byte) begin miscompares++; $display("FAIL b2b_rxdb_held: got %h expected %h", rxdb, last_byte); end
  endtask

  task automatic test_glitch;
    int fe0;
    ev_byte.delete(); ev_cyc.delete();
    fe0 = fe_cnt;
    busy_max = 0;
    rxd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(20);
    vectors++; if (ev_byte.size() != 0) begin miscompares++; $display("FAIL glitch_rxen: got %0d expected 0", ev_byte.size()); end
    vectors++; if (fe_cnt != fe0) begin miscompares++; $display("FAIL glitch_frame_err: got %0d expected 0", fe_cnt - fe0); end
    vectors++; if (busy_max < 1 || busy_max > 6) begin miscompares++; $display("FAIL glitch_busy_clocks: got %0d expected 1..6", busy_max); end
    vectors++; if (rx_busy !== 1'b0) begin miscompares++; $display("FAIL glitch_returns_idle: got %b expected 0", rx_busy); end
  endtask

  task automatic test_frame_error;
    int fall, fe0, lat;
    ev_byte.delete(); ev_cyc.delete();
    fe0 = fe_cnt;
    send_byte(8'h55, 1'b0, fall);
    rxd = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    idle(16);
    vectors++; if (fe_cnt - fe0 != 1) begin miscompares++; $display("FAIL ferr_count: got %0d expected 1", fe_cnt - fe0); end
    vectors++; if (ev_byte.size() != 0) begin miscompares++; $display("FAIL ferr_rxen: got %0d expected 0", ev_byte.size()); end
    vectors++; if (rxdb !== last_byte) begin miscompares++; $display("FAIL ferr_rxdb_kept: got %h expected %h", rxdb, last_byte); end
    vectors++; if (rx_busy !== 1'b0) begin miscompares++; $display("FAIL ferr_break_exit: got %b expected 0", rx_busy); end
    send_byte(8'h3C, 1'b1, fall);
    idle(20);
    vectors++; if (ev_byte.size() != 1) begin miscompares++; $display("FAIL ferr_next_count: got %0d expected 1", ev_byte.size()); end
    if (ev_byte.size() >= 1) begin
      lat = ev_cyc[0] - fall;
      vectors++; if (ev_byte[0] !== 8'h3C) begin miscompares++; $display("FAIL ferr_next_byte: got %h expected 3c", ev_byte[0]); end
      vectors++; if (lat < LAT_MIN || lat > LAT_MAX) begin miscompares++; $display("FAIL ferr_next_latency: got %0d expected %0d..%0d", lat, LAT_MIN, LAT_MAX); end
    end
    last_byte = 8'h3C;
  endtask

  task automatic test_reset_mid_byte;
    logic [7:0] b;
    int fall, lat;
    b = 8'hF0;
    ev_byte.delete(); ev_cyc.delete();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rxd = b[4];
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    vectors++; if (rxen !== 1'b0) begin miscompares++; $display("FAIL midrst_rxen: got %b expected 0", rxen); end
    vectors++; if (rxdb !== 8'h00) begin miscompares++; $display("FAIL midrst_rxdb: got %h expected 00", rxdb); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL midrst_frame_err: got %b expected 0", frame_err); end
    vectors++; if (rx_busy !== 1'b0) begin miscompares++; $display("FAIL midrst_rx_busy: got %b expected 0", rx_busy); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    idle(4 * CPB);
    last_byte = 8'h00;
    vectors++; if (ev_byte.size() != 0) begin miscompares++; $display("FAIL midrst_no_strobe: got %0d expected 0", ev_byte.size()); end
    send_byte(8'h81, 1'b1, fall);
    idle(20);
    vectors++; if (ev_byte.size() != 1) begin miscompares++; $display("FAIL midrst_next_count: got %0d expected 1", ev_byte.size()); end
    if (ev_byte.size() >= 1) begin
      lat = ev_cyc[0] - fall;
      vectors++; if (ev_byte[0] !== 8'h81) begin miscompares++; $display("FAIL midrst_next_byte: got %h expected 81", ev_byte[0]); end
      vectors++; if (lat < LAT_MIN || lat > LAT_MAX) begin miscompares++; $display("FAIL midrst_next_latency: got %0d expected %0d..%0d", lat, LAT_MIN, LAT_MAX); end
    end
    last_byte = 8'h81;
  endtask

  task automatic test_random_gaps;
    logic [7:0] exp_q[$];
    int         fall_q[$];
    int         fall, lat;
    ev_byte.delete(); ev_cyc.delete();
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(8'($urandom_range(0, 255)));
      send_byte(exp_q[i], 1'b1, fall);
      fall_q.push_back(fall);
      idle($urandom_range(0, 25));
    end
    idle(20);
    vectors++; if (ev_byte.size() != exp_q.size()) begin miscompares++; $display("FAIL rand_count: got %0d expected %0d", ev_byte.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      if (i < ev_byte.size()) begin
        lat = ev_cyc[i] - fall_q[i];
        vectors++; if (ev_byte[i] !== exp_q[i]) begin miscompares++; $display("FAIL rand_byte[%0d]: got %h expected %h", i, ev_byte[i], exp_q[i]); end
        vectors++; if (lat < LAT_MIN || lat > LAT_MAX) begin miscompares++; $display("FAIL rand_latency[%0d]: got %0d expected %0d..%0d", i, lat, LAT_MIN, LAT_MAX); end
      end
    end
    last_byte = exp_q[exp_q.size() - 1];
    vectors++; if (rxdb !== last_byte) begin miscompares++; $display("FAIL rand_rxdb_held: got %h expected %h", rxdb, last_byte); end
  endtask

  task automatic test_strobe_rules;
    vectors++; if (both_cnt != 0) begin miscompares++; $display("FAIL rxen_and_frame_err: got %0d overlaps expected 0", both_cnt); end
    vectors++; if (dbl_cnt != 0) begin miscompares++; $display("FAIL rxen_width: got %0d double-wide strobes expected 0", dbl_cnt); end
    vectors++; if (chg_cnt != 0) begin miscompares++; $display("FAIL rxdb_stability: got %0d changes without rxen expected 0", chg_cnt); end
  endtask

  initial begin
    test_reset;
    test_single_byte;
    test_back_to_back;
    test_glitch;
    test_frame_error;
    test_reset_mid_byte;
    test_random_gaps;
    test_strobe_rules;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
